// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 master: one INCR burst per command, local write source / read sink.
// Optional watchdog enabled by defining AXI4_BURST_MASTER_TIMEOUT_EN.
module axi4_burst_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  done_err,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] INCR   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  in_w, in_r;

    assign in_w = (state_q == S_W);
    assign in_r = (state_q == S_R);

    assign cmd_ready = ARESETn && (state_q == S_IDLE);

    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = AXSIZE;
    assign AWBURST = INCR;
    assign AWVALID = awvalid_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = AXSIZE;
    assign ARBURST = INCR;
    assign ARVALID = arvalid_q;

    // W and R channels are pure pass-throughs gated by state.
    assign WVALID   = in_w && wr_valid;
    assign wr_ready = in_w && WREADY;
    assign WDATA    = wr_data;
    assign WLAST    = in_w && (beat_q == len_q);
    assign BREADY   = (state_q == S_B);
    assign RREADY   = in_r && rd_ready;
    assign rd_valid = in_r && RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = in_r && RLAST;

    assign done     = (state_q == S_DONE);
    assign done_err = done && err_q;

`ifdef AXI4_BURST_MASTER_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        axi_hs;
    logic        active;

    assign axi_hs = (AWVALID && AWREADY) || (ARVALID && ARREADY) || (WVALID && WREADY)
                 || (BREADY && BVALID) || (RREADY && RVALID);
    assign active = (state_q != S_IDLE) && (state_q != S_DONE);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        arvalid_d = arvalid_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    beat_d = 8'd0;
                    err_d  = 1'b0;
                    if (cmd_write) begin
                        state_d   = S_AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_AW: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (wr_valid && WREADY) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) state_d = S_B;
                end
            end
            S_B: begin
                if (BVALID) begin
                    if (BRESP != 2'b00) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (RVALID && rd_ready) begin
                    beat_d = beat_q + 8'd1;
                    // Early or missing RLAST is flagged; only RLAST ends the burst.
                    if (RLAST != (beat_q == len_q)) err_d = 1'b1;
                    if (RLAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef AXI4_BURST_MASTER_TIMEOUT_EN
        wd_d = 16'd0;
        if (active && !axi_hs && (state_d == state_q)) begin
            if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                err_d     = 1'b1;
                state_d   = S_DONE;
                awvalid_d = 1'b0;
                arvalid_d = 1'b0;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

`ifdef AXI4_BURST_MASTER_TIMEOUT_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETn) wd_q <= 16'd0;
        else          wd_q <= wd_d;
    end
`endif

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master: command table, AXI slave model, reset/stray/timeout sequences.
module tb_axi4_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready = 1'b1;
    logic        done, done_err;
    logic [31:0] AWADDR, ARADDR, WDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWVALID, AWREADY = 1'b0, WLAST, WVALID, WREADY = 1'b0;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0;
    logic [31:0] RDATA = 32'd0;
    logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;

    always #5 ACLK = ~ACLK;

    axi4_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_err(done_err),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] base;
        logic [31:0] step;
        logic [1:0]  bresp;
        logic [7:0]  rlast_at;
        logic        gap;
        logic        exp_err;
    } vec_t;
    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } addr_t;

    addr_t       exp_aw[$], exp_ar[$];
    beat_t       exp_w[$], exp_rd[$];
    logic        exp_done[$];
    logic [31:0] wr_src[$], rd_src[$];

    int   n_vec = 0, n_err = 0, cyc = 0, w_hs_cnt = 0, r_last_idx = 0;
    logic gap_en = 1'b0, rdy_toggle = 1'b0, aw_stall = 1'b0, stray_r = 1'b0;
    logic [1:0] cur_bresp = 2'b00;

    always @(posedge ACLK) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_msg(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not as expected", nm);
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] base, input logic [31:0] step, input logic [1:0] bresp,
                                input logic [7:0] rlast_at, input logic gap, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.base = base; v.step = step;
        v.bresp = bresp; v.rlast_at = rlast_at; v.gap = gap; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic int pending();
        return exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size()
             + exp_done.size() + wr_src.size() + rd_src.size();
    endfunction

    task automatic flush();
        exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_rd.delete();
        exp_done.delete(); wr_src.delete(); rd_src.delete();
    endtask

    // Local write source: holds a beat until consumed, optional one-cycle gap after each beat.
    initial begin
        logic hs;
        forever begin
            @(negedge ACLK);
            hs = wr_valid && wr_ready;
            @(posedge ACLK); #1;
            if (hs && wr_src.size() > 0) void'(wr_src.pop_front());
            wr_valid = (wr_src.size() > 0) && !(gap_en && hs);
            wr_data  = (wr_src.size() > 0) ? wr_src[0] : 32'd0;
        end
    end

    // Read sink.
    initial forever begin
        @(posedge ACLK); #1;
        rd_ready = rdy_toggle ? ~rd_ready : 1'b1;
    end

    // Slave address channels.
    initial forever begin
        @(posedge ACLK); #1;
        AWREADY = ARESETn && !aw_stall && ($urandom_range(0, 2) != 0);
        ARREADY = ARESETn && ($urandom_range(0, 2) != 0);
    end

    // Slave W/B channels.
    initial begin
        logic whs, bhs, b_pend;
        b_pend = 1'b0;
        forever begin
            @(negedge ACLK);
            whs = WVALID && WREADY && WLAST;
            bhs = BVALID && BREADY;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                WREADY = 1'b0; BVALID = 1'b0; b_pend = 1'b0;
                continue;
            end
            if (whs) b_pend = 1'b1;
            if (bhs) BVALID = 1'b0;
            if (b_pend && !BVALID) begin
                BVALID = 1'b1; BRESP = cur_bresp; b_pend = 1'b0;
            end
            WREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // Slave R channel; stray_r drives an unsolicited RVALID while no read is in flight.
    initial begin
        logic arhs, rhs, r_act;
        int   r_idx;
        r_act = 1'b0; r_idx = 0;
        forever begin
            @(negedge ACLK);
            arhs = ARVALID && ARREADY;
            rhs  = RVALID && RREADY;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                RVALID = 1'b0; RLAST = 1'b0; r_act = 1'b0;
                continue;
            end
            if (rhs && r_act) begin
                if (rd_src.size() > 0) void'(rd_src.pop_front());
                if (RLAST) r_act = 1'b0;
                r_idx++;
                RVALID = 1'b0;
            end
            if (arhs) begin r_act = 1'b1; r_idx = 0; end
            if (r_act) begin
                if (!RVALID && rd_src.size() > 0 && $urandom_range(0, 3) != 0) begin
                    RVALID = 1'b1; RDATA = rd_src[0]; RLAST = (r_idx == r_last_idx);
                end
            end else begin
                RVALID = stray_r; RLAST = stray_r; RDATA = stray_r ? 32'hBAD0BAD0 : 32'd0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        addr_t a;
        beat_t b;
        logic  e, done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin done_prev = 1'b0; continue; end
            if (AWVALID && ARVALID) fail_msg("aw_ar_overlap");
            if (AWVALID && AWREADY) begin
                if (exp_aw.size() == 0) fail_msg("aw_unexpected");
                else begin
                    a = exp_aw.pop_front();
                    check("aw", 64'({AWADDR, AWLEN, AWSIZE, AWBURST}), 64'({a.addr, a.len, 3'b010, 2'b01}));
                end
            end
            if (ARVALID && ARREADY) begin
                if (exp_ar.size() == 0) fail_msg("ar_unexpected");
                else begin
                    a = exp_ar.pop_front();
                    check("ar", 64'({ARADDR, ARLEN, ARSIZE, ARBURST}), 64'({a.addr, a.len, 3'b010, 2'b01}));
                end
            end
            if (WVALID && WREADY) begin
                w_hs_cnt++;
                if (exp_w.size() == 0) fail_msg("w_unexpected");
                else begin
                    b = exp_w.pop_front();
                    check("w_beat", 64'({WDATA, WLAST}), 64'({b.data, b.last}));
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) fail_msg("rd_unexpected");
                else begin
                    b = exp_rd.pop_front();
                    check("rd_beat", 64'({rd_data, rd_last}), 64'({b.data, b.last}));
                end
            end
            if (done_prev) check("done_pulse_width", 64'(done), 64'd0);
            if (done) begin
                if (exp_done.size() == 0) fail_msg("done_unexpected");
                else begin
                    e = exp_done.pop_front();
                    check("done_err", 64'({done_err, cmd_ready}), 64'({e, 1'b0}));
                end
            end
            done_prev = done;
        end
    end

    task automatic load(input vec_t v);
        logic [31:0] d;
        gap_en = v.gap; rdy_toggle = v.gap; cur_bresp = v.bresp; r_last_idx = int'(v.rlast_at);
        if (v.wr) begin
            exp_aw.push_back('{addr: v.addr, len: v.len});
            for (int i = 0; i <= int'(v.len); i++) begin
                d = v.base + 32'(i) * v.step;
                wr_src.push_back(d);
                exp_w.push_back('{data: d, last: (i == int'(v.len))});
            end
        end else begin
            exp_ar.push_back('{addr: v.addr, len: v.len});
            for (int i = 0; i <= int'(v.rlast_at); i++) begin
                d = v.base + 32'(i) * v.step;
                rd_src.push_back(d);
                exp_rd.push_back('{data: d, last: (i == int'(v.rlast_at))});
            end
        end
        exp_done.push_back(v.exp_err);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        logic acc;
        acc = 1'b0;
        @(posedge ACLK); #1;
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge ACLK);
            acc = cmd_ready;
            @(posedge ACLK); #1;
        end
        cmd_valid = 1'b0;
        if (!acc) fail_msg("cmd_accept_timeout");
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge ACLK);
            got = done;
        end
        @(posedge ACLK); #1;
        if (!got) begin
            fail_msg("done_timeout");
            flush();
        end else begin
            check("drain", 64'(pending()), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    vec_t vecs[10];
    vec_t v;
    int   w_start;

    initial begin
        vecs[0] = mk(1'b1, 32'h100, 8'd0,   32'hDEADBEEF, 32'h0,  2'b00, 8'd0, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 32'h1000, 8'd3,  32'h11,       32'h11, 2'b00, 8'd0, 1'b1, 1'b0);
        vecs[2] = mk(1'b0, 32'h200, 8'd3,   32'hA0,       32'h1,  2'b00, 8'd3, 1'b1, 1'b0);
        vecs[3] = mk(1'b1, 32'h300, 8'd1,   32'h5000,     32'h1,  2'b10, 8'd0, 1'b0, 1'b1);
        vecs[4] = mk(1'b1, 32'h400, 8'd2,   32'h6000,     32'h1,  2'b00, 8'd0, 1'b0, 1'b0);
        vecs[5] = mk(1'b0, 32'h500, 8'd3,   32'hB0,       32'h1,  2'b00, 8'd1, 1'b0, 1'b1);
        vecs[6] = mk(1'b0, 32'h600, 8'd1,   32'hC0,       32'h1,  2'b00, 8'd2, 1'b1, 1'b1);
        vecs[7] = mk(1'b1, 32'hFFC, 8'd255, 32'h0,        32'h1,  2'b00, 8'd0, 1'b0, 1'b0);
        vecs[8] = mk(1'b0, 32'h7F0, 8'd0,   32'hE0,       32'h1,  2'b00, 8'd0, 1'b0, 1'b0);
        vecs[9] = mk(1'b1, 32'h800, 8'd7,   32'h7700,     32'h3,  2'b11, 8'd0, 1'b1, 1'b1);

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_ctrl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_ready, rd_valid,
                                 cmd_ready, done, done_err, WLAST}), 64'd0);
        check("reset_addr", 64'({AWADDR, ARADDR}), 64'd0);
        check("reset_len", 64'({AWLEN, ARLEN}), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            load(vecs[i]);
            issue(vecs[i].wr, vecs[i].addr, vecs[i].len);
            wait_done();
        end

        // Unsolicited RVALID while idle must not reach the sink.
        rdy_toggle = 1'b0;
        @(posedge ACLK); #1;
        stray_r = 1'b1;
        repeat (2) @(posedge ACLK);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check("stray_rvalid", 64'({rd_valid, RREADY, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));
        end
        @(posedge ACLK); #1;
        stray_r = 1'b0;
        repeat (3) @(posedge ACLK);

        // Reset in the middle of a len=7 write burst.
        v = mk(1'b1, 32'h900, 8'd7, 32'h9000, 32'h1, 2'b00, 8'd0, 1'b0, 1'b0);
        load(v);
        w_start = w_hs_cnt;
        issue(v.wr, v.addr, v.len);
        for (int k = 0; k < 500 && (w_hs_cnt < w_start + 2); k++) @(posedge ACLK);
        check("midburst_beats_seen", 64'(w_hs_cnt >= w_start + 2), 64'd1);
        #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("midburst_reset_outputs", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_ready,
                                             rd_valid, cmd_ready, done, WLAST}), 64'd0);
        @(posedge ACLK); #1;
        flush();
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        v = mk(1'b1, 32'hA00, 8'd1, 32'hAB00, 32'h1, 2'b00, 8'd0, 1'b0, 1'b0);
        load(v);
        issue(v.wr, v.addr, v.len);
        wait_done();

`ifdef AXI4_BURST_MASTER_TIMEOUT_EN
        begin
            int t0, t1;
            logic seen;
            aw_stall = 1'b1;
            repeat (2) @(posedge ACLK);
            exp_done.push_back(1'b1);
            issue(1'b1, 32'hC00, 8'd0);
            t0 = 0; t1 = 0; seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge ACLK);
                if (AWVALID) begin seen = 1'b1; t0 = cyc; end
            end
            seen = 1'b0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(negedge ACLK);
                if (done) begin seen = 1'b1; t1 = cyc; end
            end
            check("timeout_latency", 64'(t1 - t0), 64'd16);
            @(posedge ACLK); #1;
            aw_stall = 1'b0;
            repeat (2) @(posedge ACLK);
            check("timeout_drain", 64'(pending()), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Command-driven AXI4 master that sits directly upstream of the team's AXI4 memory controller.
- Turns single-entry burst commands (write or read, start address, length) into AXI4 INCR bursts on the AW/W/B or AR/R channels.
- Streams write data in from a local source and read data out to a local sink.
- Reports completion and error status per command.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; AxSIZE driven as log2(DATA_WIDTH/8), i.e. 3'b010 at default.
- TIMEOUT_CYCLES, 1024, watchdog limit; only used with the optional feature.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  byte start address, word aligned
- cmd_len  in  8  beats-1 (AXI LEN encoding)
- wr_data  in  DATA_WIDTH  write beat data
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed
- rd_data  out  DATA_WIDTH  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat
- rd_ready  in  1  sink accepts read beat
- done  out  1  one-cycle completion pulse
- done_err  out  1  error status, valid with done
- AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ADDR_WIDTH/8/3/2/1  AXI write address
- AWREADY  in  1
- WDATA/WLAST/WVALID  out  DATA_WIDTH/1/1
- WREADY  in  1
- BRESP  in  2
- BVALID  in  1
- BREADY  out  1
- ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ADDR_WIDTH/8/3/2/1  AXI read address
- ARREADY  in  1
- RDATA  in  DATA_WIDTH
- RLAST/RVALID  in  1/1
- RREADY  out  1

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. ACLK rising edge only; ARESETn sampled on that edge.
- Reset values:
  - all VALID/READY outputs, done, done_err, WLAST = 0;
  - AWADDR, ARADDR, AWLEN, ARLEN = 0;
  - state = IDLE, beat_cnt = 0.
- Reset mid-burst:
  - abandons the transaction immediately;
  - the bench must also reset the slave.
- AxBURST is fixed at 2'b01 (INCR). AxSIZE is fixed per DATA_WIDTH.

FSM transitions:
- IDLE: cmd_ready=1 (combinational, state==IDLE).
  - On accept: latch addr/len/dir, clear beat_cnt and err.
  - Go to AW (write) or AR (read).
- AW: AWVALID=1 registered, AWADDR/AWLEN stable.
  - On AWVALID&AWREADY: drop AWVALID the next cycle, go to W.
- W: WVALID = wr_valid; wr_ready = WREADY; WDATA = wr_data (combinational pass-through).
  - WLAST = (beat_cnt==len).
  - Each WVALID&WREADY increments beat_cnt (8-bit).
  - Handshake with WLAST=1 goes to B.
- B: BREADY=1.
  - On BVALID: err |= (BRESP!=2'b00), go to DONE.
- AR: same as AW on the AR channel; on handshake go to R.
- R: RREADY = rd_ready; rd_valid = RVALID; rd_data = RDATA; rd_last = RLAST.
  - Each RVALID&RREADY increments beat_cnt.
  - If RLAST arrives while beat_cnt!=len, or beat_cnt==len without RLAST: err=1 and stay in R; the burst ends only on an RLAST handshake.
  - RLAST handshake goes to DONE.
- DONE: done=1 and done_err=err for exactly one cycle, then IDLE.

Boundary rules:
- len=0: single beat; WLAST asserted on the first beat.
- len=255: 256 beats; beat_cnt must not wrap before WLAST.
- Address: no 4 KB crossing check; cmd_addr is forwarded unmodified.
- Commands back-to-back: cmd_ready is low from accept through DONE.
- Minimum command turnaround: 1 idle cycle after DONE.
- AWVALID/ARVALID are never withdrawn before handshake, and AW and AR are never active together.
- AXI input stability:
  - W channel: no WVALID before the AW handshake completes.
  - Read side: RVALID arriving outside R is ignored.

Optional Feature:
- Macro AXI4_BURST_MASTER_TIMEOUT_EN.
- When defined:
  - a 16-bit watchdog resets on any AXI handshake or state change, counting every cycle in AW/W/B/AR/R;
  - reaching TIMEOUT_CYCLES forces err=1 and state DONE, and drops all VALID/READY outputs.
- When undefined: no watchdog; the block may wait forever.

Test Plan:
- Write cmd addr=0x100, len=0, wr_data=0xDEADBEEF, BRESP=00 -> one AW handshake (AWADDR=0x100, AWLEN=0); one W beat with WLAST=1; done=1, done_err=0.
- Write len=3, data 0x11,0x22,0x33,0x44, wr_valid gapped every other cycle -> 4 W handshakes in order; WLAST only on 0x44; beat_cnt=4 at B.
- Read addr=0x200, len=3, slave returns 0xA0..0xA3, rd_ready toggling -> rd_data sequence A0,A1,A2,A3; rd_last only with A3; done_err=0.
- Write len=1 with BRESP=2'b10 -> done=1, done_err=1; next command accepted normally with err cleared.
- Read len=3, slave asserts RLAST on 2nd beat -> burst ends there; done_err=1.
- Assert ARESETn=0 during W beat 2 of len=7 -> next cycle all VALID/READY=0, cmd_ready=1 after release. With AXI4_BURST_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16 and AWREADY held low -> done_err=1 exactly 16 cycles after AWVALID rises.
